// File: rtl/ib_lut_loader_if.sv
// Entry-stream and IB-RAM write-port bundle for the IB LUT loader.
// master drives start/entries (config side); slave is the loader producing RAM writes.
`timescale 1ns/1ps
interface ib_lut_loader_if #(
    parameter int ENTRY_WIDTH = 4,
    parameter int PAGE_SIZE   = 4,
    parameter int ADDR_WIDTH  = 6
);
    logic                              start;
    logic                              in_valid;
    logic [ENTRY_WIDTH-1:0]            in_data;
    logic                              in_ready;
    logic                              ram_we;
    logic [ADDR_WIDTH-1:0]             ram_waddr;
    logic [PAGE_SIZE*ENTRY_WIDTH-1:0]  ram_wdata;
    logic                              busy;
    logic                              done;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, ram_we, ram_waddr, ram_wdata, busy, done
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, ram_we, ram_waddr, ram_wdata, busy, done
    );
endinterface

// File: rtl/ib_lut_loader.sv
// Packs PAGE_SIZE LUT entries per page word and writes pages into banked IB-RAM at bank-interleaved addresses.
// Write issued the cycle after a page's last entry is accepted; one entry/cycle, RAM port has no backpressure.
`timescale 1ns/1ps
module ib_lut_loader #(
    parameter int BANK_INTERLEAVE_TYPE = 0,
    parameter int BANK_INTERLEAVE_NUM  = 2,
    parameter int BANK_ADDR_WIDTH      = 1,
    parameter int PAGE_ADDR_WIDTH      = 5,
    parameter int ADDR_WIDTH           = 6,
    parameter int PAGE_SIZE            = 4,
    parameter int ENTRY_WIDTH          = 4,
    parameter int PAGE_NUM             = 32
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    ib_lut_loader_if.slave  lut
);
    localparam int SLOT_W = (PAGE_SIZE > 1) ? $clog2(PAGE_SIZE) : 1;
    localparam int WORD_W = PAGE_SIZE * ENTRY_WIDTH;
    localparam logic [SLOT_W-1:0]     LAST_SLOT = SLOT_W'(PAGE_SIZE - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_PAGE = ADDR_WIDTH'(BANK_INTERLEAVE_NUM * PAGE_NUM - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

    state_t                 state, state_nxt;
    logic [SLOT_W-1:0]      slot;
    logic [ADDR_WIDTH-1:0]  lpage;
    logic [ADDR_WIDTH-1:0]  phys_addr;
    logic [WORD_W-1:0]      pack;
    logic [WORD_W-1:0]      page_word;
    logic                   ram_we_q;
    logic [ADDR_WIDTH-1:0]  ram_waddr_q;
    logic [WORD_W-1:0]      ram_wdata_q;
    logic                   accept;
    logic                   page_full;

    assign accept    = (state == S_LOAD) && lut.in_valid;
    assign page_full = (slot == LAST_SLOT);

    // Logical page counter's low bits pick the bank, so consecutive pages rotate across banks.
    generate
        if (BANK_INTERLEAVE_TYPE == 0) begin : g_bank_major
            assign phys_addr = {lpage[BANK_ADDR_WIDTH-1:0], lpage[ADDR_WIDTH-1:BANK_ADDR_WIDTH]};
        end else begin : g_page_major
            assign phys_addr = lpage;
        end
    endgenerate

    always_comb begin
        page_word = pack;
        page_word[slot*ENTRY_WIDTH +: ENTRY_WIDTH] = lut.in_data;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        lut.in_ready = 1'b0;
        lut.done     = 1'b0;
        lut.busy     = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (lut.start) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                lut.in_ready = 1'b1;
                if (accept && page_full && (lpage == LAST_PAGE)) state_nxt = S_DONE;
            end
            S_DONE: begin
                lut.done  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // A full page is committed straight from page_word, so the pack register is free for the next page.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            slot        <= '0;
            lpage       <= '0;
            pack        <= '0;
            ram_we_q    <= 1'b0;
            ram_waddr_q <= '0;
            ram_wdata_q <= '0;
        end else begin
            ram_we_q <= 1'b0;
            if ((state == S_IDLE) && lut.start) begin
                slot  <= '0;
                lpage <= '0;
            end else if (accept) begin
                if (page_full) begin
                    ram_we_q    <= 1'b1;
                    ram_waddr_q <= phys_addr;
                    ram_wdata_q <= page_word;
                    slot        <= '0;
                    lpage       <= lpage + 1'b1;
                end else begin
                    pack <= page_word;
                    slot <= slot + 1'b1;
                end
            end
        end
    end

    assign lut.ram_we    = ram_we_q;
    assign lut.ram_waddr = ram_waddr_q;
    assign lut.ram_wdata = ram_wdata_q;
endmodule

// File: tb/tb_ib_lut_loader.sv
// Directed bench for ib_lut_loader: bank-major, page-major and 4-bank instances on one stimulus stream.
`timescale 1ns/1ps
module tb_ib_lut_loader;
    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic       sys_rst;
    logic       hold2;
    logic       rst2;
    logic       start;
    logic       in_valid;
    logic [3:0] in_data;

    assign rst2 = sys_rst | hold2;

    ib_lut_loader_if #(.ENTRY_WIDTH(4), .PAGE_SIZE(4), .ADDR_WIDTH(6)) if0 ();
    ib_lut_loader_if #(.ENTRY_WIDTH(4), .PAGE_SIZE(4), .ADDR_WIDTH(6)) if1 ();
    ib_lut_loader_if #(.ENTRY_WIDTH(4), .PAGE_SIZE(4), .ADDR_WIDTH(8)) if2 ();

    assign if0.start = start;  assign if0.in_valid = in_valid;  assign if0.in_data = in_data;
    assign if1.start = start;  assign if1.in_valid = in_valid;  assign if1.in_data = in_data;
    assign if2.start = start;  assign if2.in_valid = in_valid;  assign if2.in_data = in_data;

    ib_lut_loader #(.BANK_INTERLEAVE_TYPE(0)) u0 (.sys_clk(sys_clk), .sys_rst(sys_rst), .lut(if0));
    ib_lut_loader #(.BANK_INTERLEAVE_TYPE(1)) u1 (.sys_clk(sys_clk), .sys_rst(sys_rst), .lut(if1));
    ib_lut_loader #(
        .BANK_INTERLEAVE_TYPE(0), .BANK_INTERLEAVE_NUM(4), .BANK_ADDR_WIDTH(2),
        .PAGE_ADDR_WIDTH(6), .ADDR_WIDTH(8), .PAGE_SIZE(4), .ENTRY_WIDTH(4), .PAGE_NUM(64)
    ) u2 (.sys_clk(sys_clk), .sys_rst(rst2), .lut(if2));

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    int wa0 [0:2047];  int wd0 [0:2047];  int wy0 [0:2047];  int wk0 [0:2047];
    int wa1 [0:2047];  int wd1 [0:2047];
    int wa2 [0:2047];  int wd2 [0:2047];
    int wc0 = 0, wc1 = 0, wc2 = 0;
    int dn0 = 0, dn2 = 0, dy0 = 0, acc0 = 0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Write/done log; wk0 holds the entries accepted before each write was seen.
    always @(negedge sys_clk) begin
        if (if0.ram_we && wc0 < 2048) begin
            wa0[wc0] = int'(if0.ram_waddr);  wd0[wc0] = int'(if0.ram_wdata);
            wy0[wc0] = cyc;                  wk0[wc0] = acc0;
            wc0++;
        end
        if (if0.done) begin dn0++; dy0 = cyc; end
        if (if0.in_valid && if0.in_ready) acc0++;
        if (if1.ram_we && wc1 < 2048) begin
            wa1[wc1] = int'(if1.ram_waddr);  wd1[wc1] = int'(if1.ram_wdata);  wc1++;
        end
        if (if2.ram_we && wc2 < 2048) begin
            wa2[wc2] = int'(if2.ram_waddr);  wd2[wc2] = int'(if2.ram_wdata);  wc2++;
        end
        if (if2.done) dn2++;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_data(input int i);
        int w = 0;
        for (int j = 0; j < 4; j++) w |= ((4 * i + j) % 16) << (4 * j);
        return w;
    endfunction

    function automatic int exp_addr0(input int i);
        return (i % 2) * 32 + i / 2;
    endfunction

    task automatic run_load(input int n, input bit gaps, input bit poke, input bit sel);
        int k = 0;
        int t = 0;
        @(posedge sys_clk); #1 start = 1'b1;
        @(posedge sys_clk); #1 start = 1'b0;
        while (k < n && t < 8000) begin
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = 4'(k % 16);
            if (poke) start = ((t % 5) == 2);
            @(negedge sys_clk);
            if (in_valid && (sel ? if2.in_ready : if0.in_ready)) k++;
            @(posedge sys_clk); #1;
            t++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        chk("entries_accepted", k, n);
    endtask

    // Checks all 64 pages of one load on both the bank-major and page-major instances.
    task automatic chk_pages(input int b0, input int b1);
        for (int i = 0; i < 64; i++) begin
            chk($sformatf("t0_addr[%0d]", i), wa0[b0 + i], exp_addr0(i));
            chk($sformatf("t0_data[%0d]", i), wd0[b0 + i], exp_data(i));
            chk($sformatf("t1_addr[%0d]", i), wa1[b1 + i], i);
            chk($sformatf("t1_data[%0d]", i), wd1[b1 + i], exp_data(i));
        end
    endtask

    task automatic chk_tail(input string tag);
        @(negedge sys_clk);
        chk({tag, "_done_t1"}, int'(if0.done), 1);
        chk({tag, "_we_t1"},   int'(if0.ram_we), 1);
        chk({tag, "_busy_t1"}, int'(if0.busy), 1);
        @(negedge sys_clk);
        chk({tag, "_busy_t2"}, int'(if0.busy), 0);
        chk({tag, "_done_t2"}, int'(if0.done), 0);
    endtask

    initial begin
        int b0, b1, d0, a0, bad, b2, d2;
        sys_rst = 1'b1;  hold2 = 1'b1;
        start = 1'b0;  in_valid = 1'b0;  in_data = 4'h0;

        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("rst_in_ready", int'(if0.in_ready), 0);
        chk("rst_busy",     int'(if0.busy), 0);
        chk("rst_done",     int'(if0.done), 0);
        chk("rst_we",       int'(if0.ram_we), 0);
        chk("rst_waddr",    int'(if0.ram_waddr), 0);
        chk("rst_wdata",    int'(if0.ram_wdata), 0);
        @(posedge sys_clk); #1 sys_rst = 1'b0;

        // Gapless load
        b0 = wc0;  b1 = wc1;  d0 = dn0;
        run_load(256, 1'b0, 1'b0, 1'b0);
        chk_tail("a");
        chk("a_writes", wc0 - b0, 64);
        chk("a_writes_t1", wc1 - b1, 64);
        chk("a_done_cnt", dn0 - d0, 1);
        chk("a_done_with_last_we", dy0, wy0[b0 + 63]);
        bad = 0;
        for (int i = 1; i < 64; i++) if (wy0[b0 + i] - wy0[b0 + i - 1] != 4) bad++;
        chk("a_we_spacing_bad", bad, 0);
        chk_pages(b0, b1);

        // Random in_valid gaps
        b0 = wc0;  b1 = wc1;  d0 = dn0;  a0 = acc0;
        run_load(256, 1'b1, 1'b0, 1'b0);
        chk_tail("b");
        chk("b_writes", wc0 - b0, 64);
        chk("b_done_cnt", dn0 - d0, 1);
        bad = 0;
        for (int i = 0; i < 64; i++) if (wk0[b0 + i] - a0 != 4 * (i + 1)) bad++;
        chk("b_write_only_on_full_page_bad", bad, 0);
        chk_pages(b0, b1);

        // in_valid while idle, start re-pulsed during LOAD
        b0 = wc0;  d0 = dn0;  a0 = acc0;
        in_valid = 1'b1;  in_data = 4'hF;
        bad = 0;
        repeat (3) begin
            @(negedge sys_clk);
            if (if0.in_ready !== 1'b0 || if0.busy !== 1'b0) bad++;
            @(posedge sys_clk); #1;
        end
        chk("c_idle_not_ready_bad", bad, 0);
        chk("c_idle_nothing_accepted", acc0 - a0, 0);
        run_load(256, 1'b0, 1'b1, 1'b0);
        chk_tail("c");
        chk("c_writes", wc0 - b0, 64);
        chk("c_done_cnt", dn0 - d0, 1);
        chk("c_first_data", wd0[b0], 32'h3210);
        chk("c_last_addr", wa0[b0 + 63], 32'h3F);
        chk("c_last_data", wd0[b0 + 63], 32'hFEDC);

        // Reset after 130 entries
        b0 = wc0;  d0 = dn0;
        run_load(130, 1'b0, 1'b0, 1'b0);
        sys_rst = 1'b1;
        #1;
        chk("d_rst_we",       int'(if0.ram_we), 0);
        chk("d_rst_busy",     int'(if0.busy), 0);
        chk("d_rst_in_ready", int'(if0.in_ready), 0);
        chk("d_rst_done",     int'(if0.done), 0);
        chk("d_rst_waddr",    int'(if0.ram_waddr), 0);
        chk("d_rst_wdata",    int'(if0.ram_wdata), 0);
        chk("d_writes_before_rst", wc0 - b0, 32);
        repeat (2) @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        repeat (10) @(negedge sys_clk);
        chk("d_no_write_after_rst", wc0 - b0, 32);
        chk("d_no_done_after_rst", dn0 - d0, 0);
        @(posedge sys_clk); #1;

        b0 = wc0;  d0 = dn0;
        run_load(256, 1'b0, 1'b0, 1'b0);
        chk_tail("e");
        chk("e_writes", wc0 - b0, 64);
        chk("e_first_addr", wa0[b0], 0);
        chk("e_first_data", wd0[b0], 32'h3210);
        chk("e_last_addr", wa0[b0 + 63], 32'h3F);

        // Four-bank instance
        hold2 = 1'b0;
        b2 = wc2;  d2 = dn2;
        run_load(1024, 1'b0, 1'b0, 1'b1);
        @(negedge sys_clk);
        chk("f_done_t1", int'(if2.done), 1);
        @(negedge sys_clk);
        chk("f_busy_t2", int'(if2.busy), 0);
        chk("f_writes", wc2 - b2, 256);
        chk("f_done_cnt", dn2 - d2, 1);
        chk("f_addr_1", wa2[b2 + 1], 32'h40);
        chk("f_addr_4", wa2[b2 + 4], 32'h01);
        chk("f_addr_255", wa2[b2 + 255], 32'hFF);
        chk("f_data_0", wd2[b2], 32'h3210);
        chk("f_data_255", wd2[b2 + 255], 32'hFEDC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, observed no end, expected summary");
        $fatal(1, "time limit");
    end
endmodule

// File: doc/ib_lut_loader.md
# ib_lut_loader

Bank-interleaved write-side loader for the IB-RAM LUT macros. It accepts a stream of quantised IB LUT entries after a start pulse and packs every PAGE_SIZE entries into one page word. Each page is written into the banked IB-RAM through a single-cycle write port, at an address mapped from a logical page counter according to the bank-interleave type. It is the producer for the IB-RAM read path used by the decoder datapath; it runs at configuration or initialisation time before decoding starts.

## Interface
- BANK_INTERLEAVE_TYPE, 0: 0 = {bank_addr, page_addr}, 1 = {page_addr, bank_addr}
- BANK_INTERLEAVE_NUM, 2: number of interleaving banks (power of 2)
- BANK_ADDR_WIDTH, 1: log2(BANK_INTERLEAVE_NUM)
- PAGE_ADDR_WIDTH, 5: page address bits per bank
- ADDR_WIDTH, 6: BANK_ADDR_WIDTH+PAGE_ADDR_WIDTH
- PAGE_SIZE, 4: LUT entries per page word
- ENTRY_WIDTH, 4: bits per entry (quantisation width)
- PAGE_NUM, 32: pages per bank (2**PAGE_ADDR_WIDTH)

Ports:
- sys_clk  in  1  single clock, rising edge
- sys_rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a load when idle
- in_valid  in  1  entry-stream valid
- in_data  in  ENTRY_WIDTH  LUT entry
- in_ready  out  1  loader can accept an entry
- ram_we  out  1  IB-RAM write enable, one cycle per page
- ram_waddr  out  ADDR_WIDTH  physical IB-RAM address
- ram_wdata  out  PAGE_SIZE*ENTRY_WIDTH  packed page word
- busy  out  1  high from the cycle after an accepted start until DONE exits
- done  out  1  one-cycle completion pulse

## Operation
- Single clock domain; one asynchronous, active-high reset (sys_rst). On reset all outputs are 0, the FSM is in IDLE, and all counters and the pack register are cleared.
- FSM states are IDLE, LOAD and DONE.
  - IDLE: start=1 moves to LOAD. in_ready is 0.
  - LOAD: in_ready is 1. An entry is accepted on in_valid&in_ready. After the final entry of the final page is accepted, the FSM moves to DONE.
  - DONE: done=1 for one cycle, then the FSM returns to IDLE.
- start is ignored outside IDLE.
- Packing: entry slot counter e runs 0..PAGE_SIZE-1. Entry e goes to wdata bits [e*ENTRY_WIDTH +: ENTRY_WIDTH], so the first entry occupies the LSBs.
- When the PAGE_SIZE-th entry is accepted, the page is committed:
  - the registered ram_wdata and ram_waddr are presented with ram_we=1 on the next cycle;
  - logical page counter L increments, and e wraps to 0.
- L runs 0..BANK_INTERLEAVE_NUM*PAGE_NUM-1 (ADDR_WIDTH bits), so consecutive logical pages rotate across banks.
- Address mapping:
  - bank = L[BANK_ADDR_WIDTH-1:0]
  - page = L[ADDR_WIDTH-1:BANK_ADDR_WIDTH]
  - TYPE 0: ram_waddr = {bank, page}
  - TYPE 1: ram_waddr = {page, bank}, which equals L
- in_valid gaps: e and L hold, and no write is issued.
- in_valid while in_ready=0: the entry is dropped with no side effect.
- The RAM write port has no backpressure, so throughput is one entry per cycle sustained.
- Total entries per load = BANK_INTERLEAVE_NUM*PAGE_NUM*PAGE_SIZE, 256 at defaults.
- Reset mid-load: immediate return to IDLE. The partial page is discarded, and no write or done is issued.
- ram_wdata holds its last value when ram_we=0. Its content is don't-care for checking except while ram_we=1.

## Timing
- Write latency: ram_we is asserted in cycle t+1, where t is the cycle in which the last entry of the page is accepted.
- in_ready rises in the cycle after start is sampled.
- Final page: in_ready falls at t+1 (the FSM is in DONE). ram_we and done are both asserted at t+1, and busy falls at t+2.
- No write ever coincides with an entry acceptance into the same page slot; the pack register captures the next page while the previous write is presented.
- Back-to-back loads: start is accepted in the cycle after DONE, when the FSM is back in IDLE.

## Test plan
- Defaults, TYPE 0; start, then 256 entries with value k mod 16, no gaps:
  - 1st write: addr 0x00, data 0x3210
  - 2nd write: addr 0x20, data 0x7654
  - 3rd write: addr 0x01
  - 64th write: addr 0x3F
  - exactly 64 ram_we pulses, one every 4 cycles; done pulses once, together with the 64th ram_we; busy low the next cycle
- Same stream with TYPE 1: the i-th write goes to addr i (0..63), with identical data words.
- Random in_valid gaps (about 50% duty): same address/data sequence as the TYPE 0 run; no write issued while a page is incomplete.
- start pulsed during LOAD and in_valid asserted in IDLE: no state change, no entry consumed, write count still 64.
- sys_rst asserted after 130 entries (page 32, slot 2): all outputs 0 immediately, no further write, no done pulse; a subsequent full load again starts at addr 0x00 with data 0x3210.
- BANK_INTERLEAVE_NUM=4, ADDR_WIDTH=8, PAGE_NUM=64, TYPE 0, 1024 entries: 2nd write addr 0x40, 5th write addr 0x01, last (256th) write addr 0xFF.
